// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning the HI/LO pair
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_we_q, pend_we_d;
  logic          done_q, done_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] rs_abs, rt_abs, dvs_u, dvs_s;
  logic [31:0] q_u, r_u, q_mag, r_mag, q_s, r_s;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  always_comb begin
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u = {32'b0, rs} * {32'b0, rt};
    rs_abs = rs[31] ? -rs : rs;
    rt_abs = rt[31] ? -rt : rt;
    dvs_u  = (rt == 32'd0) ? 32'd1 : rt;
    dvs_s  = (rt_abs == 32'd0) ? 32'd1 : rt_abs;
    q_u    = rs / dvs_u;
    r_u    = rs % dvs_u;
    q_mag  = rs_abs / dvs_s;
    r_mag  = rs_abs % dvs_s;
    q_s    = (rs[31] ^ rt[31]) ? -q_mag : q_mag;
    r_s    = rs[31] ? -r_mag : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_we_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = RUN;
            end
            3'b001: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_we_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = RUN;
            end
            3'b010: begin
              pend_hi_d = r_s;
              pend_lo_d = q_s;
              pend_we_d = (rt != 32'd0);
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = RUN;
            end
            3'b011: begin
              pend_hi_d = r_u;
              pend_lo_d = q_u;
              pend_we_d = (rt != 32'd0);
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = RUN;
            end
            3'b100:  hi_d = rs;
            3'b101:  lo_d = rs;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Divide by zero leaves HI/LO untouched but still completes normally.
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      done_q    <= done_d;
    end
  end

  // Combinational start term lets a mult/div in ID stall behind one entering EX.
  assign busy = (state_q == RUN) | (start & ~op[2]);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
